// File: rtl/serial_sub_ctrl_pkg.sv
// Shared definitions for the bit-serial subtraction sequencer: FSM encodings
// and the counter-width helper.
package serial_sub_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Counter width is clog2(w), but never narrower than one bit.
  function automatic int cnt_bits(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_sub_ctrl_if.sv
// Request/result bundle for serial_sub_ctrl.
// Handshake: an operation is accepted on a rising edge where start=1 and ready=1;
// start is ignored otherwise. done pulses for one cycle while diff/bout hold the result.
interface serial_sub_ctrl_if #(
  parameter int WIDTH = 8
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  modport master (
    output start, a, b, bin,
    input  ready, busy, done, diff, bout
  );

  modport slave (
    input  start, a, b, bin,
    output ready, busy, done, diff, bout
  );
endinterface

// File: rtl/serial_sub_ctrl_fs.sv
// One-bit full-subtractor cell: diff = a - b - bin, brr set when a borrow is needed.
module fs (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic brr
);
  assign diff = a ^ b ^ bin;
  assign brr  = (~a & b) | (~a & bin) | (b & bin);
endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor sequencer: drives one fs cell LSB-first, one bit per clock,
// and returns diff = a - b - bin with the final borrow.
module serial_sub_ctrl
  import serial_sub_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  serial_sub_ctrl_if.slave   bus,
  output state_t             dbg_state
);
  localparam int CW = cnt_bits(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] diff_r;
  logic             brw;
  logic             bout_r;
  logic [CW-1:0]    cnt;
  logic             cell_d;
  logic             cell_b;
  logic [WIDTH:0]   res_ext;

  fs u_fs (
    .a   (a_sr[0]),
    .b   (b_sr[0]),
    .bin (brw),
    .diff(cell_d),
    .brr (cell_b)
  );

  // New diff bit enters at the MSB; the widened vector keeps WIDTH=1 legal.
  assign res_ext = {cell_d, res};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res    <= '0;
      diff_r <= '0;
      brw    <= 1'b0;
      bout_r <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            a_sr  <= bus.a;
            b_sr  <= bus.b;
            brw   <= bus.bin;
            cnt   <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          res  <= res_ext[WIDTH:1];
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          brw  <= cell_b;
          if (cnt == CW'(WIDTH - 1)) begin
            diff_r <= res_ext[WIDTH:1];
            bout_r <= cell_b;
            state  <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.ready = (state == ST_IDLE);
  assign bus.busy  = (state == ST_RUN);
  assign bus.done  = (state == ST_DONE);
  assign bus.diff  = diff_r;
  assign bus.bout  = bout_r;
  assign dbg_state = state;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Bench for serial_sub_ctrl: an 8-bit and a 1-bit instance, driver tasks feeding
// expected-result queues, and per-instance monitors that pop on each done pulse.
module tb_serial_sub_ctrl;
  import serial_sub_ctrl_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  serial_sub_ctrl_if #(.WIDTH(8)) bus8 ();
  serial_sub_ctrl_if #(.WIDTH(1)) bus1 ();
  state_t st8;
  state_t st1;

  serial_sub_ctrl #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .bus(bus8), .dbg_state(st8));
  serial_sub_ctrl #(.WIDTH(1)) u1 (.clk(clk), .rst(rst), .bus(bus1), .dbg_state(st1));

  // scoreboard queues: {bout, diff} and the cycle done is due
  logic [8:0] exp_q8[$];
  logic [8:0] exp_q1[$];
  int         cyc_q8[$];
  int         cyc_q1[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain modular arithmetic and an unsigned compare.
  function automatic logic [8:0] model(input int a, input int b, input int bin, input int w);
    int m;
    int d;
    logic [8:0] r;
    m = 1 << w;
    d = ((a - b - bin) % m + m) % m;
    r = 9'(d);
    r[8] = (a < b + bin);
    return r;
  endfunction

  // driver tasks
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                     input bit hold, input bit push);
    int n = 0;
    @(negedge clk);
    while (!bus8.ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus8.ready) begin
      check("ready_timeout8", bus8.ready, 1);
      return;
    end
    bus8.a = a; bus8.b = b; bus8.bin = bin; bus8.start = 1'b1;
    @(posedge clk); #1;
    if (push) begin
      exp_q8.push_back(model(int'(a), int'(b), int'(bin), 8));
      cyc_q8.push_back(cyc + 8);
    end
    if (!hold) bus8.start = 1'b0;
  endtask

  task automatic op1(input logic a, input logic b, input logic bin);
    int n = 0;
    @(negedge clk);
    while (!bus1.ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus1.ready) begin
      check("ready_timeout1", bus1.ready, 1);
      return;
    end
    bus1.a = a; bus1.b = b; bus1.bin = bin; bus1.start = 1'b1;
    @(posedge clk); #1;
    exp_q1.push_back(model(int'(a), int'(b), int'(bin), 1));
    cyc_q1.push_back(cyc + 1);
    bus1.start = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while ((exp_q8.size() != 0 || exp_q1.size() != 0) && n < limit) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
  endtask

  // monitors
  logic prev_done8 = 1'b0;
  logic prev_done1 = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      prev_done8 <= 1'b0;
    end else begin
      check("onehot8", $countones({bus8.ready, bus8.busy, bus8.done}), 1);
      if (bus8.done) begin
        check("done_width8", prev_done8, 0);
        check("pending8", exp_q8.size() > 0, 1);
        if (exp_q8.size() > 0) begin
          logic [8:0] e;
          int c;
          e = exp_q8.pop_front();
          c = cyc_q8.pop_front();
          check("diff8", bus8.diff, e[7:0]);
          check("bout8", bus8.bout, e[8]);
          check("latency8", cyc, c);
        end
      end
      prev_done8 <= bus8.done;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      prev_done1 <= 1'b0;
    end else begin
      check("onehot1", $countones({bus1.ready, bus1.busy, bus1.done}), 1);
      if (bus1.done) begin
        check("done_width1", prev_done1, 0);
        check("pending1", exp_q1.size() > 0, 1);
        if (exp_q1.size() > 0) begin
          logic [8:0] e;
          int c;
          e = exp_q1.pop_front();
          c = cyc_q1.pop_front();
          check("diff1", bus1.diff, e[0]);
          check("bout1", bus1.bout, e[8]);
          check("latency1", cyc, c);
        end
      end
      prev_done1 <= bus1.done;
    end
  end

  // stimulus
  initial begin
    rst = 1'b1;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.bin = 1'b0;
    bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.bin = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", bus8.ready, 1);
    check("rst_busy", bus8.busy, 0);
    check("rst_done", bus8.done, 0);
    check("rst_diff", bus8.diff, 0);
    check("rst_bout", bus8.bout, 0);
    check("rst_state", st8, ST_IDLE);
    rst = 1'b0;

    // directed cases
    op8(8'h5A, 8'h3C, 1'b0, 0, 1);
    op8(8'h00, 8'h01, 1'b0, 0, 1);
    op8(8'hFF, 8'hFF, 1'b1, 0, 1);
    wait_idle(100);

    // start during RUN with other operands must be ignored
    op8(8'h5A, 8'h3C, 1'b0, 0, 1);
    repeat (2) @(negedge clk);
    bus8.a = 8'h01; bus8.b = 8'hF0; bus8.bin = 1'b1; bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    wait_idle(100);

    // start held high: back-to-back acceptance every WIDTH+2 cycles
    op8(8'h10, 8'h01, 1'b0, 1, 1);
    op8(8'h80, 8'h7F, 1'b0, 0, 1);
    wait_idle(100);

    // reset mid-RUN: abandoned, no done pulse
    op8(8'hC3, 8'h12, 1'b1, 0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_ready", bus8.ready, 1);
    check("midrst_busy", bus8.busy, 0);
    check("midrst_done", bus8.done, 0);
    check("midrst_diff", bus8.diff, 0);
    check("midrst_bout", bus8.bout, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_ready", bus8.ready, 1);
    op8(8'h33, 8'h44, 1'b1, 0, 1);
    wait_idle(100);

    // WIDTH=1 truth table
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      op1(v[2], v[1], v[0]);
    end
    wait_idle(100);

    // random scoreboard run
    for (int i = 0; i < 1000; i++) begin
      op8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
          1'($urandom_range(0, 1)), 0, 1);
      if (i % 8 == 0) op1(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_idle(200);
    check("drain8", exp_q8.size(), 0);
    check("drain1", exp_q1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
